// File: rtl/ni_flit_injector_if.sv
// ni_flit_injector_if: packet request, payload stream, flit output and
// credit return between a packet source, the injector and a router FIFO.
// Ports: pkt_* request, pld_* payload, flit_* to FIFO, credit_in from FIFO.
interface ni_flit_injector_if #(
  parameter int DATA_WIDTH = 32,
  parameter int LEN_W      = 4
);
  logic                  pkt_req;
  logic [3:0]            pkt_dst;
  logic [LEN_W-1:0]      pkt_len;
  logic                  pkt_ack;
  logic                  pld_valid;
  logic [DATA_WIDTH-1:0] pld_data;
  logic                  pld_ready;
  logic                  flit_valid;
  logic [2:0]            flit_id;
  logic [DATA_WIDTH-1:0] flit_data;
  logic                  credit_in;

  modport master (
    output pkt_req, pkt_dst, pkt_len,
    input  pkt_ack,
    output pld_valid, pld_data,
    input  pld_ready,
    input  flit_valid, flit_id, flit_data,
    output credit_in
  );

  modport slave (
    input  pkt_req, pkt_dst, pkt_len,
    output pkt_ack,
    input  pld_valid, pld_data,
    output pld_ready,
    output flit_valid, flit_id, flit_data,
    input  credit_in
  );
endinterface

// File: rtl/ni_flit_injector.sv
// ni_flit_injector: builds HEADER/PAYLOAD*/TAIL wormhole packets and
// injects them into a router input FIFO under credit flow control.
// Ports: clk, rst (sync, active high), cur_addr_rst (own {y,x}, latched
// in reset), bus (slave side of ni_flit_injector_if), busy, credit_err.
module ni_flit_injector #(
  parameter int FIFO_DEPTH = 4,
  parameter int DATA_WIDTH = 32,
  parameter int LEN_W      = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [3:0]          cur_addr_rst,
  ni_flit_injector_if.slave   bus,
  output logic                busy,
  output logic                credit_err
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW-1:0] CRED_MAX = CW'(FIFO_DEPTH);
  localparam logic [2:0] ID_HDR  = 3'b001;
  localparam logic [2:0] ID_PLD  = 3'b010;
  localparam logic [2:0] ID_TAIL = 3'b100;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BODY,
    S_TAIL
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [LEN_W-1:0]      r_rem;
  logic [LEN_W-1:0]      w_rem_nxt;
  logic [CW-1:0]         r_credits;
  logic [3:0]            r_own;
  logic                  r_flit_valid;
  logic [2:0]            r_flit_id;
  logic [DATA_WIDTH-1:0] r_flit_data;
  logic                  r_busy;
  logic                  r_credit_err;

  logic                  w_has_cred;
  logic                  w_send;
  logic                  w_ack;
  logic                  w_rdy;
  logic [2:0]            w_id;
  logic [DATA_WIDTH-1:0] w_data;
  logic [DATA_WIDTH-1:0] w_hdr;

  assign w_has_cred = (r_credits != '0);

  always_comb begin
    w_hdr               = '0;
    w_hdr[3:0]          = bus.pkt_dst;
    w_hdr[7:4]          = r_own;
    w_hdr[8 +: LEN_W]   = bus.pkt_len;
  end

  // rem counts payload words still owed; the last word rides in the TAIL.
  always_comb begin
    w_state_nxt = r_state;
    w_rem_nxt   = r_rem;
    w_send      = 1'b0;
    w_ack       = 1'b0;
    w_rdy       = 1'b0;
    w_id        = '0;
    w_data      = '0;
    if (!rst) begin
      unique case (r_state)
        S_IDLE: begin
          if (bus.pkt_req && w_has_cred) begin
            w_ack       = 1'b1;
            w_send      = 1'b1;
            w_id        = ID_HDR;
            w_data      = w_hdr;
            w_rem_nxt   = bus.pkt_len;
            w_state_nxt = (bus.pkt_len >= LEN_W'(2)) ? S_BODY : S_TAIL;
          end
        end
        S_BODY: begin
          if (bus.pld_valid && w_has_cred) begin
            w_rdy     = 1'b1;
            w_send    = 1'b1;
            w_id      = ID_PLD;
            w_data    = bus.pld_data;
            w_rem_nxt = r_rem - LEN_W'(1);
            if (r_rem == LEN_W'(2)) w_state_nxt = S_TAIL;
          end
        end
        S_TAIL: begin
          if (r_rem == '0) begin
            // empty packet: TAIL carries no payload word
            if (w_has_cred) begin
              w_send      = 1'b1;
              w_id        = ID_TAIL;
              w_state_nxt = S_IDLE;
            end
          end else if (bus.pld_valid && w_has_cred) begin
            w_rdy       = 1'b1;
            w_send      = 1'b1;
            w_id        = ID_TAIL;
            w_data      = bus.pld_data;
            w_rem_nxt   = '0;
            w_state_nxt = S_IDLE;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_rem        <= '0;
      r_credits    <= CRED_MAX;
      r_own        <= cur_addr_rst;
      r_flit_valid <= 1'b0;
      r_flit_id    <= '0;
      r_flit_data  <= '0;
      r_busy       <= 1'b0;
      r_credit_err <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_rem        <= w_rem_nxt;
      r_flit_valid <= w_send;
      r_flit_id    <= w_id;
      r_flit_data  <= w_data;
      r_busy       <= (w_state_nxt != S_IDLE);
      unique case (1'b1)
        (w_send && !bus.credit_in):
          r_credits <= r_credits - CW'(1);
        (bus.credit_in && !w_send): begin
          if (r_credits == CRED_MAX) r_credit_err <= 1'b1;
          else r_credits <= r_credits + CW'(1);
        end
        default: ;
      endcase
    end
  end

  assign bus.pkt_ack    = w_ack;
  assign bus.pld_ready  = w_rdy;
  assign bus.flit_valid = r_flit_valid;
  assign bus.flit_id    = r_flit_id;
  assign bus.flit_data  = r_flit_data;
  assign busy           = r_busy;
  assign credit_err     = r_credit_err;

endmodule
